// File: rtl/alu_result_stage.sv
// =============================================================================
// alu_result_stage
// -----------------------------------------------------------------------------
// Execute-to-writeback stage that sits directly after the main ALU.
//   * Owns the architectural flags register that feeds the ALU flag input.
//   * Buffers register-writing results in a 2-entry skid FIFO and presents
//     the oldest entry to the register-file write port over valid/ready, so
//     a stalled writeback never drops a result.
//
// Ports
//   clk, reset_n         clock / asynchronous active-low reset
//   in_valid, in_ready   upstream handshake (in_ready depends on wb_ready only)
//   in_result/in_flags   ALU result and flag vector
//   in_dest              destination register index
//   in_wr_reg            operation writes a register (enqueues a FIFO entry)
//   in_wr_flags          operation commits in_flags to the flags register
//   flags                architectural flags (bits indexed by pkg_cpu::flag_idx_e)
//   wb_valid, wb_ready   writeback handshake
//   wb_data, wb_dest     oldest buffered entry (registered storage)
//   occupancy            number of buffered entries, 0..2
//
// Optional feature (macro RESULT_FORWARD_EN)
//   fwd_reg  in   register index to look up among buffered entries
//   fwd_hit  out  some valid entry targets fwd_reg
//   fwd_data out  data of the youngest matching entry, 0 when no match
// =============================================================================

package pkg_cpu;
    // Bit positions inside the flags vector.
    typedef enum int unsigned {
        FlagC = 0,
        FlagZ = 1,
        FlagV = 2,
        FlagN = 3
    } flag_idx_e;
endpackage : pkg_cpu

module alu_result_stage #(
    parameter int WORD_WIDTH    = 32,
    parameter int REG_IDX_WIDTH = 4,
    parameter int FLAGS_WIDTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_WIDTH-1:0]    in_result,
    input  logic [FLAGS_WIDTH-1:0]   in_flags,
    input  logic [REG_IDX_WIDTH-1:0] in_dest,
    input  logic                     in_wr_reg,
    input  logic                     in_wr_flags,

    output logic [FLAGS_WIDTH-1:0]   flags,

    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [WORD_WIDTH-1:0]    wb_data,
    output logic [REG_IDX_WIDTH-1:0] wb_dest,
    output logic [1:0]               occupancy
`ifdef RESULT_FORWARD_EN
    ,
    input  logic [REG_IDX_WIDTH-1:0] fwd_reg,
    output logic                     fwd_hit,
    output logic [WORD_WIDTH-1:0]    fwd_data
`endif
);

    // The state encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [WORD_WIDTH-1:0]    data;
        logic [REG_IDX_WIDTH-1:0] dest;
    } entry_t;

    state_e state;
    entry_t mem [2];
    logic   wr_ptr;
    logic   rd_ptr;

    logic accept;
    logic push;
    logic drain;

    // A full buffer can still take a new op when the oldest entry leaves in
    // the same cycle; the freed slot is the one being written.
    assign in_ready  = (state != ST_FULL) | wb_ready;
    assign accept    = in_valid & in_ready;
    assign push      = accept & in_wr_reg;
    assign drain     = wb_valid & wb_ready;

    assign wb_valid  = (state != ST_EMPTY);
    assign occupancy = state;
    assign wb_data   = mem[rd_ptr].data;
    assign wb_dest   = mem[rd_ptr].dest;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every read in this block sees the pre-edge value regardless of order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            flags  <= '0;
            // NOTE: the storage is reset because wb_data/wb_dest are read
            // straight from it and must show zero out of reset.
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept && in_wr_flags) begin
                flags <= in_flags;
            end

            if (push) begin
                mem[wr_ptr] <= '{data: in_result, dest: in_dest};
                wr_ptr      <= ~wr_ptr;
            end

            if (drain) begin
                rd_ptr <= ~rd_ptr;
            end

            case (state)
                ST_EMPTY: begin
                    if (push) state <= ST_ONE;
                end
                ST_ONE: begin
                    if (push && !drain)      state <= ST_FULL;
                    else if (drain && !push) state <= ST_EMPTY;
                end
                ST_FULL: begin
                    // push without drain cannot happen: in_ready is low then.
                    if (drain && !push) state <= ST_ONE;
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

`ifdef RESULT_FORWARD_EN
    // When full, the write pointer has wrapped onto the read pointer, so the
    // younger entry is always the slot opposite the oldest one.
    logic young_ptr;
    assign young_ptr = ~rd_ptr;

    // NOTE: every output of this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (state != ST_EMPTY && mem[rd_ptr].dest == fwd_reg) begin
            fwd_hit  = 1'b1;
            fwd_data = mem[rd_ptr].data;
        end
        // The younger match overrides the older one.
        if (state == ST_FULL && mem[young_ptr].dest == fwd_reg) begin
            fwd_hit  = 1'b1;
            fwd_data = mem[young_ptr].data;
        end
    end
`endif

endmodule : alu_result_stage
